// File: rtl/gfx_pkg.sv
// Shared encodings, widths and stage bundles for pixel_addr_gen.
// Build macro BILINEAR_EN: 4-tap bilinear; otherwise 1-tap nearest.
package gfx_pkg;

  localparam logic [1:0] MODE_ID    = 2'd0;
  localparam logic [1:0] MODE_TR    = 2'd1;
  localparam logic [1:0] MODE_ROT   = 2'd2;
  localparam logic [1:0] MODE_ROTTR = 2'd3;

  localparam int Q_FRAC  = 14;
  localparam int ONE_Q14 = 16384;
  localparam int FRAC_W  = 8;

  localparam logic [1:0] TAP_00 = 2'd0;
  localparam logic [1:0] TAP_10 = 2'd1;
  localparam logic [1:0] TAP_01 = 2'd2;
  localparam logic [1:0] TAP_11 = 2'd3;

`ifdef BILINEAR_EN
  localparam int N_TAPS = 4;
`else
  localparam int N_TAPS = 1;
`endif

  typedef struct packed {
    logic [10:0] xl;
    logic [9:0]  yl;
    logic [1:0]  mode;
    logic [15:0] cs;
    logic [15:0] sn;
    logic [11:0] tx;
    logic [10:0] ty;
  } xf_in_t;

  typedef struct packed {
    logic [9:0]        x;
    logic [9:0]        x1;
    logic [9:0]        y;
    logic [9:0]        y1;
    logic [FRAC_W-1:0] fx;
    logic [FRAC_W-1:0] fy;
    logic              oob;
  } xf_out_t;

  function automatic logic [9:0] clamp_c(
    input logic signed [31:0] v,
    input int                 hi
  );
    logic [9:0] r;
    if (v < 0)
      r = '0;
    else if (v > hi)
      r = 10'(hi);
    else
      r = v[9:0];
    return r;
  endfunction

endpackage

// File: rtl/coord_xform.sv
// coord_xform: S2 products and S3 sum/shift/clamp of the source coordinate.
// Build macro BILINEAR_EN keeps the fraction; otherwise integer is rounded.
module coord_xform
  import gfx_pkg::*;
#(
  parameter int FB_W = 800,
  parameter int FB_H = 600,
  parameter int CX   = 400,
  parameter int CY   = 300
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_v,
  input  xf_in_t  i_d,
  output logic    o_v,
  output xf_out_t o_d
);

  logic signed [31:0] w_cs, w_sn, w_dx, w_dy;
  logic signed [31:0] r_cdx, r_sdy, r_sdx, r_cdy;
  logic               r_v2;
  logic [10:0]        r_xl;
  logic [9:0]         r_yl;
  logic [1:0]         r_mode;
  logic [11:0]        r_tx;
  logic [10:0]        r_ty;

  assign w_cs = 32'($signed(i_d.cs));
  assign w_sn = 32'($signed(i_d.sn));
  assign w_dx = $signed({21'b0, i_d.xl}) - CX;
  assign w_dy = $signed({22'b0, i_d.yl}) - CY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_cdx  <= '0;
      r_sdy  <= '0;
      r_sdx  <= '0;
      r_cdy  <= '0;
      r_xl   <= '0;
      r_yl   <= '0;
      r_mode <= MODE_ID;
      r_tx   <= '0;
      r_ty   <= '0;
    end else begin
      r_v2   <= i_v;
      r_cdx  <= w_cs * w_dx;
      r_sdy  <= w_sn * w_dy;
      r_sdx  <= w_sn * w_dx;
      r_cdy  <= w_cs * w_dy;
      r_xl   <= i_d.xl;
      r_yl   <= i_d.yl;
      r_mode <= i_d.mode;
      r_tx   <= i_d.tx;
      r_ty   <= i_d.ty;
    end
  end

  logic               w_rot, w_trn;
  logic signed [31:0] w_xs, w_ys, w_xr, w_yr, w_xi, w_yi;
  logic [9:0]         w_x, w_y;
  xf_out_t            w_o;

  assign w_rot = (r_mode == MODE_ROT) || (r_mode == MODE_ROTTR);
  assign w_trn = (r_mode == MODE_TR) || (r_mode == MODE_ROTTR);

  assign w_xs =
    (w_rot ? r_cdx - r_sdy + (CX <<< Q_FRAC)
           : $signed({7'b0, r_xl, 14'b0}))
    + (w_trn ? $signed({{6{r_tx[11]}}, r_tx, 14'b0})
             : 32'sd0);
  assign w_ys =
    (w_rot ? r_sdx + r_cdy + (CY <<< Q_FRAC)
           : $signed({8'b0, r_yl, 14'b0}))
    + (w_trn ? $signed({{7{r_ty[10]}}, r_ty, 14'b0})
             : 32'sd0);

`ifdef BILINEAR_EN
  assign w_xr = w_xs;
  assign w_yr = w_ys;
`else
  assign w_xr = w_xs + (32'sd1 <<< (Q_FRAC - 1));
  assign w_yr = w_ys + (32'sd1 <<< (Q_FRAC - 1));
`endif

  assign w_xi = w_xr >>> Q_FRAC;
  assign w_yi = w_yr >>> Q_FRAC;
  assign w_x  = clamp_c(w_xi, FB_W - 1);
  assign w_y  = clamp_c(w_yi, FB_H - 1);

  always_comb begin
    w_o     = '0;
    w_o.x   = w_x;
    w_o.y   = w_y;
    w_o.x1  = (w_x == 10'(FB_W - 1)) ? w_x : w_x + 10'd1;
    w_o.y1  = (w_y == 10'(FB_H - 1)) ? w_y : w_y + 10'd1;
    w_o.oob = (w_xi < 0) || (w_xi >= FB_W)
           || (w_yi < 0) || (w_yi >= FB_H);
`ifdef BILINEAR_EN
    w_o.fx  = w_xs[Q_FRAC-1 -: FRAC_W];
    w_o.fy  = w_ys[Q_FRAC-1 -: FRAC_W];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_v <= 1'b0;
      o_d <= '0;
    end else begin
      o_v <= r_v2;
      o_d <= w_o;
    end
  end

endmodule

// File: rtl/pixel_addr_gen.sv
// pixel_addr_gen: look-ahead, frame shadow regs, address multiply, tap FSM.
// Build macro BILINEAR_EN: 4 taps/pixel with fractions; else 1 tap nearest.
module pixel_addr_gen
  import gfx_pkg::*;
#(
  parameter int H_TOTAL   = 1056,
  parameter int V_TOTAL   = 628,
  parameter int LOOKAHEAD = 11,
  parameter int FB_W      = 800,
  parameter int FB_H      = 600,
  parameter int CX        = 400,
  parameter int CY        = 300,
  parameter int ADDR_W    = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic [1:0]        mode,
  input  logic [15:0]       cos_q,
  input  logic [15:0]       sin_q,
  input  logic [11:0]       tx,
  input  logic [10:0]       ty,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic [1:0]        tap_idx,
  output logic [7:0]        frac_x,
  output logic [7:0]        frac_y,
  output logic              oob,
  output logic              busy,
  output logic              overrun
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  localparam logic [1:0] LAST_TAP = 2'(N_TAPS - 1);

  logic [11:0] w_hsum;
  logic        w_wrap, w_fs, w_hit;
  logic [10:0] w_xl;
  logic [9:0]  w_yn, w_yl;

  assign w_hsum = {1'b0, hcount} + 12'(LOOKAHEAD);
  assign w_wrap = w_hsum >= 12'(H_TOTAL);
  assign w_xl   = w_wrap ? 11'(w_hsum - 12'(H_TOTAL))
                         : w_hsum[10:0];
  assign w_yn   = (vcount == 10'(V_TOTAL - 1)) ? '0
                                                : vcount + 10'd1;
  assign w_yl   = w_wrap ? w_yn : vcount;
  assign w_fs   = pix_ce && (hcount == '0) && (vcount == '0);

  logic [1:0]  r_mode;
  logic [15:0] r_cos, r_sin;
  logic [11:0] r_tx;
  logic [10:0] r_ty;
  logic        r_s1_v, r_ovr;
  logic [1:0]  r_guard;
  xf_in_t      r_s1;

  // r_guard counts cycles until a new pixel can no longer cut a burst short
  assign w_hit = pix_ce && (r_guard != 2'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode  <= MODE_ID;
      r_cos   <= 16'(ONE_Q14);
      r_sin   <= '0;
      r_tx    <= '0;
      r_ty    <= '0;
      r_s1_v  <= 1'b0;
      r_s1    <= '0;
      r_guard <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_fs) begin
        r_mode <= mode;
        r_cos  <= cos_q;
        r_sin  <= sin_q;
        r_tx   <= tx;
        r_ty   <= ty;
      end
      r_s1_v    <= pix_ce;
      r_s1.xl   <= w_xl;
      r_s1.yl   <= w_yl;
      r_s1.mode <= w_fs ? mode  : r_mode;
      r_s1.cs   <= w_fs ? cos_q : r_cos;
      r_s1.sn   <= w_fs ? sin_q : r_sin;
      r_s1.tx   <= w_fs ? tx    : r_tx;
      r_s1.ty   <= w_fs ? ty    : r_ty;
      if (pix_ce)
        r_guard <= LAST_TAP;
      else if (r_guard != 2'd0)
        r_guard <= r_guard - 2'd1;
      if (w_fs)
        r_ovr <= 1'b0;
      else if (w_hit)
        r_ovr <= 1'b1;
    end
  end

  logic    w_s3_v;
  xf_out_t w_s3;

  coord_xform #(
    .FB_W (FB_W),
    .FB_H (FB_H),
    .CX   (CX),
    .CY   (CY)
  ) u_xf (
    .clk   (clk),
    .rst_n (reset),
    .i_v   (r_s1_v),
    .i_d   (r_s1),
    .o_v   (w_s3_v),
    .o_d   (w_s3)
  );

  logic [ADDR_W-1:0] w_row0, w_row1, w_a0, w_an;
  logic [ADDR_W-1:0] r_row0, r_row1, r_x0, r_x1, r_addr;
  logic [0:0]        r_state;
  logic [1:0]        r_tap, w_tap_n;
  logic              r_valid, r_oob;
  logic [7:0]        r_fx, r_fy;

  assign w_row0  = ADDR_W'(w_s3.y) * ADDR_W'(FB_W);
  assign w_row1  = ADDR_W'(w_s3.y1) * ADDR_W'(FB_W);
  assign w_a0    = w_row0 + ADDR_W'(w_s3.x);
  assign w_tap_n = r_tap + 2'd1;

  always_comb begin
    w_an = r_row0 + r_x0;
    unique case (1'b1)
      (w_tap_n == TAP_10): w_an = r_row0 + r_x1;
      (w_tap_n == TAP_01): w_an = r_row1 + r_x0;
      (w_tap_n == TAP_11): w_an = r_row1 + r_x1;
      default:             w_an = r_row0 + r_x0;
    endcase
  end

  // a fresh S3 result always wins: the old burst stops at this tap boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_tap   <= TAP_00;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_row0  <= '0;
      r_row1  <= '0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_fx    <= '0;
      r_fy    <= '0;
      r_oob   <= 1'b0;
    end else if (w_s3_v) begin
      r_state <= ST_BURST;
      r_tap   <= TAP_00;
      r_valid <= 1'b1;
      r_addr  <= w_a0;
      r_row0  <= w_row0;
      r_row1  <= w_row1;
      r_x0    <= ADDR_W'(w_s3.x);
      r_x1    <= ADDR_W'(w_s3.x1);
      r_fx    <= w_s3.fx;
      r_fy    <= w_s3.fy;
      r_oob   <= w_s3.oob;
    end else if (r_state == ST_BURST) begin
      if (r_tap == LAST_TAP) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
      end else begin
        r_tap  <= w_tap_n;
        r_addr <= w_an;
      end
    end
  end

  assign addr       = r_addr;
  assign addr_valid = r_valid;
  assign tap_idx    = r_tap;
  assign frac_x     = r_fx;
  assign frac_y     = r_fy;
  assign oob        = r_oob;
  assign busy       = (r_state == ST_BURST);
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_pixel_addr_gen.sv
// tb_pixel_addr_gen: vector table plus scoreboard of expected taps.
// Follows the BILINEAR_EN build setting for tap count and fractions.
module tb_pixel_addr_gen;

`ifdef BILINEAR_EN
  localparam int NT = 4;
`else
  localparam int NT = 1;
`endif

  logic        clk;
  logic        reset;
  logic        pix_ce;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [1:0]  mode;
  logic [15:0] cos_q, sin_q;
  logic [11:0] tx;
  logic [10:0] ty;
  logic [18:0] addr;
  logic        addr_valid;
  logic [1:0]  tap_idx;
  logic [7:0]  frac_x, frac_y;
  logic        oob, busy, overrun;

  pixel_addr_gen dut (
    .clk        (clk),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .hcount     (hcount),
    .vcount     (vcount),
    .mode       (mode),
    .cos_q      (cos_q),
    .sin_q      (sin_q),
    .tx         (tx),
    .ty         (ty),
    .addr       (addr),
    .addr_valid (addr_valid),
    .tap_idx    (tap_idx),
    .frac_x     (frac_x),
    .frac_y     (frac_y),
    .oob        (oob),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int  addr;
    int  tap;
    int  fx;
    int  fy;
    bit  oob;
  } exp_t;

  typedef struct {
    int m, c, s, tx, ty, h, v, a0;
    bit o0;
  } vec_t;

  exp_t q[$];
  vec_t tab[10];
  int   checks = 0;
  int   errors = 0;
  int   sm_mode, sm_c, sm_s, sm_tx, sm_ty;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic shadow_reset();
    sm_mode = 0; sm_c = 16384; sm_s = 0;
    sm_tx = 0; sm_ty = 0;
  endtask

  task automatic set_params(input int m, c, s, x, y);
    mode  = 2'(m);
    cos_q = 16'(c);
    sin_q = 16'(s);
    tx    = 12'(x);
    ty    = 11'(y);
  endtask

  task automatic push_px(input int h, v, n,
                         input bit ovr, input int ta,
                         input bit to);
    int xl, yl, xs, ys, xi, yi;
    int x, y, x1, y1, fx, fy;
    int ax[4], ay[4];
    bit ob;
    exp_t e;
    if (h == 0 && v == 0) begin
      sm_mode = int'(mode);
      sm_c = int'($signed(cos_q));
      sm_s = int'($signed(sin_q));
      sm_tx = int'($signed(tx));
      sm_ty = int'($signed(ty));
    end
    xl = h + 11; yl = v;
    if (xl >= 1056) begin
      xl -= 1056;
      yl = (v == 627) ? 0 : v + 1;
    end
    if (sm_mode >= 2) begin
      xs = sm_c*(xl-400) - sm_s*(yl-300) + 400*16384;
      ys = sm_s*(xl-400) + sm_c*(yl-300) + 300*16384;
    end else begin
      xs = xl * 16384; ys = yl * 16384;
    end
    if (sm_mode == 1 || sm_mode == 3) begin
      xs += sm_tx * 16384; ys += sm_ty * 16384;
    end
    if (NT == 4) begin
      xi = xs >>> 14; yi = ys >>> 14;
      fx = (xs >>> 6) & 255; fy = (ys >>> 6) & 255;
    end else begin
      xi = (xs + 8192) >>> 14; yi = (ys + 8192) >>> 14;
      fx = 0; fy = 0;
    end
    ob = xi < 0 || xi >= 800 || yi < 0 || yi >= 600;
    x = xi < 0 ? 0 : (xi > 799 ? 799 : xi);
    y = yi < 0 ? 0 : (yi > 599 ? 599 : yi);
    x1 = x < 799 ? x + 1 : 799;
    y1 = y < 599 ? y + 1 : 599;
    ax = '{x, x1, x, x1};
    ay = '{y, y, y1, y1};
    for (int k = 0; k < n; k++) begin
      e.addr = ay[k]*800 + ax[k];
      e.tap = k; e.fx = fx; e.fy = fy; e.oob = ob;
      if (k == 0 && ovr) begin
        e.addr = ta; e.oob = to;
      end
      q.push_back(e);
    end
  endtask

  task automatic send(input int h, v, gap,
                      input bit ovr, input int ta,
                      input bit to);
    hcount = 11'(h);
    vcount = 10'(v);
    pix_ce = 1'b1;
    push_px(h, v, gap < NT ? gap : NT, ovr, ta, to);
    @(posedge clk); #1;
    pix_ce = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain left %0d want 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
    chk("busy_idle", busy, 0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && addr_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_tap addr %0d want none", addr);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("addr", addr, e.addr);
        chk("tap_idx", tap_idx, e.tap);
        chk("frac_x", frac_x, e.fx);
        chk("frac_y", frac_y, e.fy);
        chk("oob", oob, e.oob);
        chk("busy", busy, 1);
      end
    end
  end

  initial begin
    tab[0] = '{0, 16384, 0, 0, 0, 0, 0, 11, 0};
    tab[1] = '{0, 16384, 0, 0, 0, 1050, 5, 4805, 0};
    tab[2] = '{0, 16384, 0, 0, 0, 1050, 627, 5, 0};
    tab[3] = '{2, 0, 16384, 0, 0, 489, 300, 320400, 0};
    tab[4] = '{1, 16384, 0, -900, 0, 100, 50, 40000, 1};
    tab[5] = '{1, 16384, 0, 10, 0, 778, 20, 16799, 0};
    tab[6] = '{1, 16384, 0, 10, 0, 790, 20, 16799, 1};
    tab[7] = '{3, 0, 16384, 5, -3, 489, 300, 318005, 0};
    tab[8] = '{1, 16384, 0, 0, -400, 0, 10, 11, 1};
    tab[9] = '{2, 16384, 0, 0, 0, 100, 100, 80111, 0};

    reset = 1'b0; pix_ce = 1'b0;
    hcount = '0; vcount = '0;
    set_params(0, 16384, 0, 0, 0);
    shadow_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", addr, 0);
    chk("rst_valid", addr_valid, 0);
    chk("rst_tap", tap_idx, 0);
    chk("rst_frac", {frac_x, frac_y}, 0);
    chk("rst_oob", oob, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      set_params(tab[i].m, tab[i].c, tab[i].s,
                 tab[i].tx, tab[i].ty);
      send(0, 0, NT, 0, 0, 0);
      send(tab[i].h, tab[i].v, NT, 1,
           tab[i].a0, tab[i].o0);
    end
    drain();

    for (int p = 0; p < 2; p++) begin
      if (p == 0) set_params(3, 11585, 11585, -7, 13);
      else        set_params(2, 14189, -8192, 0, 0);
      send(0, 0, NT, 0, 0, 0);
      for (int i = 0; i < 8; i++)
        send(int'($urandom_range(0, 1055)),
             int'($urandom_range(0, 627)),
             NT, 0, 0, 0);
    end
    drain();

    set_params(2, 0, 16384, 0, 0);
    send(0, 0, NT, 0, 0, 0);
    set_params(0, 16384, 0, 100, 100);
    send(489, 300, NT, 1, 320400, 0);
    send(0, 0, NT, 0, 0, 0);
    send(489, 300, NT, 1, 240500, 0);
    drain();

    chk("ovr_clear0", overrun, 0);
    send(100, 50, 2, 0, 0, 0);
    send(200, 60, 2, 0, 0, 0);
    send(300, 70, NT, 0, 0, 0);
    chk("ovr_set", overrun, (NT > 1) ? 1 : 0);
    drain();
    send(0, 0, NT, 0, 0, 0);
    chk("ovr_frame_clr", overrun, 0);
    drain();

    set_params(2, 0, 16384, 0, 0);
    send(0, 0, NT, 0, 0, 0);
    drain();
    send(300, 100, 2, 0, 0, 0);
    hcount = 11'd400; vcount = 10'd100;
    pix_ce = 1'b1;
    @(posedge clk); #1;
    pix_ce = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", addr_valid, 1);
    @(negedge clk); #1;
    reset = 1'b0;
    q.delete();
    #1;
    chk("rst_async_valid", addr_valid, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_ovr", overrun, 0);
    #2;
    reset = 1'b1;
    shadow_reset();
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("flush_valid", addr_valid, 0);
    send(489, 300, NT, 1, 240500, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
